// File: rtl/dca_matrix_load2mreg_pingpong_if.sv
// Row-load and matrix-register write/read-release signals between the tensor-load DMA,
// the ping-pong loader and the matrix register file.
interface dca_matrix_load2mreg_pingpong_if #(
    parameter int MATRIX_NUM_ROW = 4,
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_SCALAR      = 8,
    parameter int NUM_MREG       = 2
);
    localparam int BW_ROW  = MATRIX_NUM_COL * BW_SCALAR;
    localparam int BW_SEL  = (NUM_MREG > 1) ? $clog2(NUM_MREG) : 1;
    localparam int BW_RIDX = $clog2(MATRIX_NUM_ROW);

    // valid/ready: a row moves on every clock edge where wvalid & wready are both high;
    // wvalid, wlast and wdata hold until accepted, and wready may fall without a beat.
    logic               load_tensor_row_wvalid;
    logic               load_tensor_row_wlast;
    logic [BW_ROW-1:0]  load_tensor_row_wdata;
    logic               load_tensor_row_wready;
    logic               mreg_move_wenable;
    logic [BW_SEL-1:0]  mreg_move_wsel;
    logic [BW_RIDX-1:0] mreg_move_wrow;
    logic [BW_ROW-1:0]  mreg_move_wdata_list1d;
    logic               loadreg_rready;
    logic [BW_SEL-1:0]  loadreg_rsel;
    logic               loadreg_rrequest;

    modport slave (
        input  load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
        input  loadreg_rrequest,
        output load_tensor_row_wready,
        output mreg_move_wenable, mreg_move_wsel, mreg_move_wrow, mreg_move_wdata_list1d,
        output loadreg_rready, loadreg_rsel
    );

    modport master (
        output load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
        output loadreg_rrequest,
        input  load_tensor_row_wready,
        input  mreg_move_wenable, mreg_move_wsel, mreg_move_wrow, mreg_move_wdata_list1d,
        input  loadreg_rready, loadreg_rsel
    );
endinterface

// File: rtl/dca_matrix_load2mreg_pingpong.sv
// Streams tensor rows round-robin into NUM_MREG matrix-register banks with zero padding and column masking.
// Optional macro DCA_LOAD2MREG_OVERFLOW_ERR_EN: sticky err_overflow when an over-long matrix is dropped.
module dca_matrix_load2mreg_pingpong #(
    parameter int MATRIX_NUM_ROW = 4,
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_SCALAR      = 8,
    parameter int NUM_MREG       = 2
) (
    input  logic                                  clk,
    input  logic                                  rstnn,
    input  logic                                  clear,
    input  logic                                  enable,
    output logic                                  busy,
    input  logic [$clog2(MATRIX_NUM_COL+1)-1:0]   cfg_num_col,
    output logic                                  err_overflow,
    dca_matrix_load2mreg_pingpong_if.slave        bus
);
    localparam int BW_ROW  = MATRIX_NUM_COL * BW_SCALAR;
    localparam int BW_SEL  = (NUM_MREG > 1) ? $clog2(NUM_MREG) : 1;
    localparam int BW_RIDX = $clog2(MATRIX_NUM_ROW);
    localparam int BW_FULL = $clog2(NUM_MREG + 1);
    localparam logic [BW_RIDX-1:0] ROW_LAST = BW_RIDX'(MATRIX_NUM_ROW - 1);
    localparam logic [BW_FULL-1:0] FULL_MAX = BW_FULL'(NUM_MREG);

    typedef enum logic [1:0] {S_LOAD, S_PAD, S_DRAIN} state_t;

    state_t             state, state_nx;
    logic [BW_RIDX-1:0] row_cnt, row_cnt_nx;
    logic [BW_SEL-1:0]  wr_ptr, rd_ptr;
    logic [BW_FULL-1:0] full_cnt;
    logic               done, release_bank, wready_c, accept_c;
    logic [BW_ROW-1:0]  row_masked;

    function automatic logic [BW_SEL-1:0] ptr_inc(input logic [BW_SEL-1:0] p);
        return (p == BW_SEL'(NUM_MREG - 1)) ? '0 : p + 1'b1;
    endfunction

    // A zero or out-of-range column count means the full row width.
    always_comb begin
        row_masked = '0;
        for (int i = 0; i < MATRIX_NUM_COL; i++) begin
            if (cfg_num_col == '0 || int'(cfg_num_col) > MATRIX_NUM_COL || i < int'(cfg_num_col))
                row_masked[BW_SCALAR*i +: BW_SCALAR] = bus.load_tensor_row_wdata[BW_SCALAR*i +: BW_SCALAR];
        end
    end

    always_comb begin
        state_nx   = state;
        row_cnt_nx = row_cnt;
        done       = 1'b0;
        wready_c   = 1'b0;
        accept_c   = 1'b0;
        bus.mreg_move_wenable      = 1'b0;
        bus.mreg_move_wdata_list1d = '0;
        case (state)
            S_LOAD: begin
                wready_c = enable && (full_cnt != FULL_MAX);
                accept_c = bus.load_tensor_row_wvalid && wready_c;
                if (accept_c) begin
                    bus.mreg_move_wenable      = 1'b1;
                    bus.mreg_move_wdata_list1d = row_masked;
                    if (row_cnt == ROW_LAST) begin
                        done       = 1'b1;
                        row_cnt_nx = '0;
                        if (!bus.load_tensor_row_wlast) state_nx = S_DRAIN;
                    end else begin
                        row_cnt_nx = row_cnt + 1'b1;
                        if (bus.load_tensor_row_wlast) state_nx = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (enable) begin
                    bus.mreg_move_wenable = 1'b1;
                    if (row_cnt == ROW_LAST) begin
                        done       = 1'b1;
                        row_cnt_nx = '0;
                        state_nx   = S_LOAD;
                    end else begin
                        row_cnt_nx = row_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                wready_c = enable;
                accept_c = bus.load_tensor_row_wvalid && wready_c;
                if (accept_c && bus.load_tensor_row_wlast) state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    assign release_bank               = enable && bus.loadreg_rrequest && (full_cnt != '0);
    assign bus.load_tensor_row_wready = wready_c;
    assign bus.mreg_move_wsel         = wr_ptr;
    assign bus.mreg_move_wrow         = row_cnt;
    assign bus.loadreg_rready         = (full_cnt != '0);
    assign bus.loadreg_rsel           = rd_ptr;
    assign busy                       = (row_cnt != '0) || (state != S_LOAD);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state    <= S_LOAD;
            row_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_cnt <= '0;
        end else if (clear) begin
            state    <= S_LOAD;
            row_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_cnt <= '0;
        end else begin
            state   <= state_nx;
            row_cnt <= row_cnt_nx;
            if (done)         wr_ptr <= ptr_inc(wr_ptr);
            if (release_bank) rd_ptr <= ptr_inc(rd_ptr);
            // Completing and releasing on the same edge leaves the occupancy unchanged.
            if (done && !release_bank)      full_cnt <= full_cnt + 1'b1;
            else if (!done && release_bank) full_cnt <= full_cnt - 1'b1;
        end
    end

`ifdef DCA_LOAD2MREG_OVERFLOW_ERR_EN
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)                                      err_overflow <= 1'b0;
        else if (clear)                                  err_overflow <= 1'b0;
        else if (state != S_DRAIN && state_nx == S_DRAIN) err_overflow <= 1'b1;
    end
`else
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dca_matrix_load2mreg_pingpong.sv
// Randomized bench for dca_matrix_load2mreg_pingpong against a bank-queue reference model,
// preceded by directed sequences with hand-computed expectations.
module tb_dca_matrix_load2mreg_pingpong;
    localparam int NROW = 4;
    localparam int NCOL = 4;
    localparam int BWS  = 8;
    localparam int NM   = 2;
    localparam int BW_ROW  = NCOL * BWS;
    localparam int BW_SEL  = (NM > 1) ? $clog2(NM) : 1;
    localparam int BW_RIDX = $clog2(NROW);
    localparam int BW_CFG  = $clog2(NCOL + 1);
    localparam int W = BW_SEL + BW_RIDX + BW_ROW;

    // clock / reset
    logic clk = 1'b0;
    logic rstnn = 1'b0;
    logic clear = 1'b0;
    logic enable = 1'b0;
    logic busy, err_overflow;
    logic [BW_CFG-1:0] cfg_num_col = '0;
    always #5 clk = ~clk;

    dca_matrix_load2mreg_pingpong_if #(.MATRIX_NUM_ROW(NROW), .MATRIX_NUM_COL(NCOL),
        .BW_SCALAR(BWS), .NUM_MREG(NM)) bus_if ();

    dca_matrix_load2mreg_pingpong #(.MATRIX_NUM_ROW(NROW), .MATRIX_NUM_COL(NCOL),
        .BW_SCALAR(BWS), .NUM_MREG(NM)) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy),
        .cfg_num_col(cfg_num_col), .err_overflow(err_overflow), .bus(bus_if));

    // reference model: open-bank row count, pending pad rows, drop mode, queue of full banks
    int m_rows, m_pad, m_wbank;
    bit m_drop, m_err, m_acc;
    int full_q[$];
    logic [W-1:0] exp_q[$];
    int n_vec = 0, n_mis = 0;
    int in_beats = 0, in_target = 1;

    // captured DUT outputs of the latest step
    logic c_wready, c_wen, c_rready, c_busy, c_err;
    logic [BW_SEL-1:0]  c_wsel, c_rsel;
    logic [BW_RIDX-1:0] c_wrow;
    logic [BW_ROW-1:0]  c_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW_ROW-1:0] mask_row(input logic [BW_ROW-1:0] d, input int cfg);
        logic [BW_ROW-1:0] r = '0;
        int eff = (cfg == 0 || cfg > NCOL) ? NCOL : cfg;
        for (int i = 0; i < eff; i++) r[BWS*i +: BWS] = d[BWS*i +: BWS];
        return r;
    endfunction

    task automatic model_reset();
        m_rows = 0; m_pad = 0; m_wbank = 0; m_drop = 0; m_err = 0;
        full_q.delete();
        exp_q.delete();
        in_beats = 0;
    endtask

    // one clock: drive, compare against model, advance model at the edge
    task automatic step(input logic en, input logic wv, input logic wl, input logic [BW_ROW-1:0] wd,
                        input logic [BW_CFG-1:0] cfg, input logic rq);
        bit e_wready, pad_wr, data_wr, e_wen, e_busy, e_err, rel, was_drop;
        logic [BW_ROW-1:0] e_data;
        logic [W-1:0] got, exp;
        @(negedge clk);
        enable = en;
        bus_if.load_tensor_row_wvalid = wv;
        bus_if.load_tensor_row_wlast  = wl;
        bus_if.load_tensor_row_wdata  = wd;
        bus_if.loadreg_rrequest       = rq;
        cfg_num_col = cfg;
        #1;
        e_wready = en && (m_pad == 0) && (m_drop || full_q.size() < NM);
        m_acc    = wv && e_wready;
        pad_wr   = en && (m_pad > 0);
        data_wr  = m_acc && !m_drop;
        e_wen    = pad_wr || data_wr;
        e_data   = pad_wr ? '0 : mask_row(wd, int'(cfg));
        e_busy   = (m_rows != 0) || (m_pad > 0) || m_drop;
`ifdef DCA_LOAD2MREG_OVERFLOW_ERR_EN
        e_err = m_err;
`else
        e_err = 1'b0;
`endif
        c_wready = bus_if.load_tensor_row_wready;
        c_wen    = bus_if.mreg_move_wenable;
        c_wsel   = bus_if.mreg_move_wsel;
        c_wrow   = bus_if.mreg_move_wrow;
        c_wdata  = bus_if.mreg_move_wdata_list1d;
        c_rready = bus_if.loadreg_rready;
        c_rsel   = bus_if.loadreg_rsel;
        c_busy   = busy;
        c_err    = err_overflow;
        check("wready", 64'(c_wready), 64'(e_wready));
        check("wenable", 64'(c_wen), 64'(e_wen));
        check("rready", 64'(c_rready), 64'(full_q.size() != 0));
        if (full_q.size() != 0) check("rsel", 64'(c_rsel), 64'(full_q[0]));
        check("busy", 64'(c_busy), 64'(e_busy));
        check("err_overflow", 64'(c_err), 64'(e_err));
        if (e_wen) exp_q.push_back({BW_SEL'(m_wbank), BW_RIDX'(m_rows), e_data});
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = {c_wsel, c_wrow, c_wdata};
            if (c_wen) check("write_sel_row_data", 64'(got), 64'(exp));
        end
        @(posedge clk);
        rel = rq && en && (full_q.size() != 0);
        was_drop = m_drop;
        if (rel) void'(full_q.pop_front());
        if (e_wen) begin
            m_rows++;
            if (pad_wr) m_pad--;
            if (data_wr && wl && m_rows < NROW) m_pad = NROW - m_rows;
            if (m_rows == NROW) begin
                full_q.push_back(m_wbank);
                m_wbank = (m_wbank + 1) % NM;
                m_rows = 0;
                if (data_wr && !wl) begin m_drop = 1; m_err = 1; end
            end
        end
        if (m_acc && was_drop && wl) m_drop = 0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; enable = 1'b0;
        bus_if.load_tensor_row_wvalid = 1'b0;
        bus_if.loadreg_rrequest = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstnn = 1'b0; enable = 1'b0;
        bus_if.load_tensor_row_wvalid = 1'b0;
        bus_if.loadreg_rrequest = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstnn = 1'b1;
    endtask

    initial begin
        bus_if.load_tensor_row_wvalid = 1'b0;
        bus_if.load_tensor_row_wlast  = 1'b0;
        bus_if.load_tensor_row_wdata  = '0;
        bus_if.loadreg_rrequest       = 1'b0;
        model_reset();
        do_reset();

        // reset state
        step(1, 0, 0, 32'h0, 3'd4, 0);
        check("lit_rst_wready", 64'(c_wready), 64'd1);
        check("lit_rst_busy", 64'(c_busy), 64'd0);
        check("lit_rst_rready", 64'(c_rready), 64'd0);

        // full matrix into bank0
        for (int r = 0; r < 4; r++) step(1, 1, r == 3, 32'hA0A0A0A0 + r, 3'd4, 0);
        check("lit_a_wrow", 64'(c_wrow), 64'd3);
        check("lit_a_wsel", 64'(c_wsel), 64'd0);
        step(1, 0, 0, 32'h0, 3'd4, 0);
        check("lit_a_rready", 64'(c_rready), 64'd1);
        check("lit_a_rsel", 64'(c_rsel), 64'd0);

        // short matrix with two active columns into bank1
        step(1, 1, 0, 32'h44332211, 3'd2, 0);
        check("lit_b_mask", 64'(c_wdata), 64'h00002211);
        check("lit_b_wsel", 64'(c_wsel), 64'd1);
        step(1, 1, 1, 32'h55667788, 3'd2, 0);
        step(1, 1, 0, 32'hFFFFFFFF, 3'd4, 0);
        check("lit_b_pad_wready", 64'(c_wready), 64'd0);
        check("lit_b_pad_wdata", 64'(c_wdata), 64'd0);
        check("lit_b_pad_wrow", 64'(c_wrow), 64'd2);
        step(1, 0, 0, 32'h0, 3'd4, 0);
        step(1, 1, 0, 32'h0, 3'd4, 0);
        check("lit_full_wready", 64'(c_wready), 64'd0);

        // release bank0, third matrix goes into bank0
        step(1, 1, 0, 32'h0C0C0C00, 3'd4, 1);
        for (int r = 0; r < 4; r++) begin
            step(1, 1, r == 3, 32'h0C0C0C00 + r, 3'd4, 0);
            if (r == 0) check("lit_c_wsel", 64'(c_wsel), 64'd0);
        end
        step(1, 0, 0, 32'h0, 3'd4, 1);
        // last row and release in the same cycle
        for (int r = 0; r < 4; r++) step(1, 1, r == 3, 32'hD0D0D000 + r, 3'd4, r == 3);
        step(1, 0, 0, 32'h0, 3'd4, 0);
        check("lit_d_rready", 64'(c_rready), 64'd1);
        check("lit_d_rsel", 64'(c_rsel), 64'd1);

        // six-row matrix: rows 4,5 dropped
        for (int r = 0; r < 6; r++) begin
            step(1, 1, r == 5, 32'hE0E0E000 + r, 3'd4, 0);
            if (r == 4) begin
                check("lit_e_drop_wen", 64'(c_wen), 64'd0);
                check("lit_e_drop_wready", 64'(c_wready), 64'd1);
            end
        end
        step(1, 0, 0, 32'h0, 3'd4, 0);
`ifdef DCA_LOAD2MREG_OVERFLOW_ERR_EN
        check("lit_e_err", 64'(c_err), 64'd1);
`else
        check("lit_e_err", 64'(c_err), 64'd0);
`endif
        do_clear();
        step(1, 0, 0, 32'h0, 3'd4, 0);
        check("lit_clr_rready", 64'(c_rready), 64'd0);
        check("lit_clr_err", 64'(c_err), 64'd0);

        // randomized traffic
        in_beats = 0;
        in_target = $urandom_range(1, 6);
        for (int n = 0; n < 4000; n++) begin
            logic en, wv, wl, rq;
            if ($urandom_range(0, 399) == 0) begin
                do_reset(); in_target = $urandom_range(1, 6);
            end else if ($urandom_range(0, 299) == 0) begin
                do_clear(); in_target = $urandom_range(1, 6);
            end
            en = ($urandom_range(0, 9) != 0);
            wv = ($urandom_range(0, 3) != 0);
            wl = (in_beats == in_target - 1);
            rq = ($urandom_range(0, 2) == 0);
            step(en, wv, wl, $urandom(), BW_CFG'($urandom_range(0, 7)), rq);
            if (m_acc) begin
                if (wl) begin in_beats = 0; in_target = $urandom_range(1, 6); end
                else in_beats++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
